conv5x5_filter: RTL and testbench
=================================

# conv5x5_filter

Programmable 5x5 convolution stage for the HDMI image-filter path. It consumes the five vertically aligned row taps and the delayed video timing from the line buffer directly upstream. It forms a 5x5 window with horizontal shift registers, applies a signed coefficient kernel, then normalises, clamps and outputs one filtered pixel per input pixel, with timing signals delayed to match. It also zero-masks rows that belong to the previous frame at the top of each image.

## Interface
- COLORDEPTH, 8, unsigned pixel width
- COEFW, 8, signed coefficient width
- clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- dv_i  in  1  pixel valid from line buffer
- hs_i  in  1  hsync from line buffer (delayed only)
- vs_i  in  1  vsync, active-high; rising edge = frame start
- row0_i..row4_i  in  COLORDEPTH each  vertical taps; row0 = current line y, rowk = line y-k
- coeff_i  in  25*COEFW  kernel; coefficient (r,c) at bits [(5r+c)*COEFW +: COEFW]; r = row index, c = 0 newest pixel .. 4 oldest
- shift_i  in  4  right-shift normalisation, 0..15
- dv_o, hs_o, vs_o  out  1 each  timing delayed by LATENCY
- data_o  out  COLORDEPTH  filtered pixel

## Operation
- Coefficient shadow: coeff_i and shift_i are loaded into internal registers only on the vs_i rising edge (vs_i=1, previous vs_i=0). They are used from the next cycle. Mid-frame changes on coeff_i are ignored.
- Line counter line_cnt (3 bits, saturates at 4):
  - Cleared on the vs_i rising edge.
  - Incremented on each dv_i falling edge.
  - Both events in the same cycle: clear wins.
- Row mask: in the input stage, rowk is replaced by 0 when k > line_cnt. This removes the previous frame's rows from the top lines of the image.
- Window: 5x5 register array.
  - When dv_i=1: column 0 loads the masked rows; columns 1..4 shift from 0..3.
  - When dv_i=0: the whole window is cleared to 0. This gives zero padding at the left edge of each line.
- Output pixel x = sum of coeff(r,c)*window(r,c). It is aligned to the newest column, so the filter centre lies 2 pixels and 2 lines behind the output position; this spatial offset is accepted by design.
- Arithmetic:
  - Pixels are zero-extended to signed.
  - Each product is COLORDEPTH+COEFW+1 bits, signed.
  - Total sum is product width + 5 bits.
  - The sum is arithmetic-shifted right by shift.
  - The result is clamped to the range [0, 2^COLORDEPTH-1].
- Pipeline stages:
  - S1: window register.
  - S2: 25 products registered.
  - S3: 5 row sums registered.
  - S4: total sum registered.
  - S5: shift and clamp into data_o.
- dv_o, hs_o and vs_o come from a 5-deep shift register on dv_i, hs_i and vs_i.
- data_o is not forced to 0 when dv_o=0; downstream qualifies it with dv_o.

## Timing
- LATENCY = 5 cycles, fixed.
  - A pixel sampled with dv_i at edge t appears on data_o with dv_o=1 after edge t+5.
  - Throughput is 1 pixel per clock, with no stall.
- Reset values:
  - All outputs are 0.
  - Window, pipeline, delay lines and line_cnt are 0.
  - Shadow kernel is identity: coeff(2,2)=1, all others 0; shift=0.
- Reset mid-line: dv_o, hs_o, vs_o and data_o are 0 after the reset edge. The shadow kernel returns to identity. Normal output resumes 5 cycles after the first dv_i following reset release.
- First 4 outputs of each line include zero-padded columns. No right-edge padding cycles are generated.
- line_cnt saturates at 4 and does not wrap.
- A vs_i rising edge while dv_i=1 still loads the shadow registers and clears line_cnt.

## Test plan
- Reset, identity kernel, no vs edge:
  - Stimulus: third line of a frame (line_cnt=2), row2 = 10,20,30,40,50.
  - Required: data_o = 0,0,10,20,30 on consecutive dv_o cycles. First dv_o is 5 cycles after the first dv_i.
- Box kernel:
  - Stimulus: all 25 coefficients = 1, shift=5, loaded via a vs rising edge. Line ≥4, all rows 255.
  - Required: interior pixels give 6375>>5 = 199. The first column gives 5*255>>5 = 39.
- Clamp:
  - Stimulus: coeff(0,0) = -1, pixel 50.
  - Required: data_o = 0.
  - Stimulus: all coefficients = 1, shift=0, pixels 255.
  - Required: data_o = 255.
- Row mask:
  - Stimulus: coeff(r,0) = 1 for all r, shift=0, all rows 10, after a vs rising edge.
  - Required: lines 0,1,2,3,4,5 give 10,20,30,40,50,50.
- Shadow load:
  - Stimulus: change coeff_i mid-frame.
  - Required: output unchanged until the next vs rising edge, then the new kernel applies from the following cycle.
- Mid-line reset:
  - Stimulus: assert rst for 1 cycle during dv_i.
  - Required: dv_o=0 next cycle, and the identity kernel is restored.

Source files
------------

// File: rtl/conv5x5_filter.sv
// conv5x5_filter: programmable 5x5 convolution stage with top-of-frame row masking,
// a five-register pipeline (window, products, row sums, total, shift/clamp) and matched timing.
module conv5x5_filter #(
  parameter int COLORDEPTH = 8,
  parameter int COEFW      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dv_i,
  input  logic                    hs_i,
  input  logic                    vs_i,
  input  logic [COLORDEPTH-1:0]   row0_i,
  input  logic [COLORDEPTH-1:0]   row1_i,
  input  logic [COLORDEPTH-1:0]   row2_i,
  input  logic [COLORDEPTH-1:0]   row3_i,
  input  logic [COLORDEPTH-1:0]   row4_i,
  input  logic [25*COEFW-1:0]     coeff_i,
  input  logic [3:0]              shift_i,
  output logic                    dv_o,
  output logic                    hs_o,
  output logic                    vs_o,
  output logic [COLORDEPTH-1:0]   data_o
);

  localparam int PW = COLORDEPTH + COEFW + 1;
  localparam int SW = PW + 5;
  localparam int KW = 25 * COEFW;
  localparam logic [KW-1:0] IDENTITY = KW'(1) << (12 * COEFW);

  logic                   vs_prev;
  logic                   dv_prev;
  logic                   vs_rise;
  logic                   dv_fall;
  logic [2:0]             line_cnt;
  logic [KW-1:0]          coeff_sh;
  logic [3:0]             shift_sh;

  logic [COLORDEPTH-1:0]  row_in   [5];
  logic [COLORDEPTH-1:0]  row_mask [5];
  logic [COLORDEPTH-1:0]  win      [5][5];

  logic signed [PW-1:0]   pix_ext  [25];
  logic signed [PW-1:0]   coef_ext [25];
  logic signed [PW-1:0]   prod_c   [25];
  logic signed [PW-1:0]   prod     [25];
  logic signed [SW-1:0]   row_sum_c [5];
  logic signed [SW-1:0]   row_sum   [5];
  logic signed [SW-1:0]   total_c;
  logic signed [SW-1:0]   total;
  logic signed [SW-1:0]   shifted;
  logic [COLORDEPTH-1:0]  pix_c;
  logic [3:0]             shift_s2;
  logic [3:0]             shift_s3;
  logic [3:0]             shift_s4;

  logic [4:0]             dv_d;
  logic [4:0]             hs_d;
  logic [4:0]             vs_d;

  assign vs_rise = vs_i & ~vs_prev;
  assign dv_fall = dv_prev & ~dv_i;

  // Kernel shadow and line counter; a frame start overrides a line end in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev  <= 1'b0;
      dv_prev  <= 1'b0;
      line_cnt <= 3'd0;
      coeff_sh <= IDENTITY;
      shift_sh <= 4'd0;
    end else begin
      vs_prev <= vs_i;
      dv_prev <= dv_i;
      if (vs_rise) begin
        coeff_sh <= coeff_i;
        shift_sh <= shift_i;
        line_cnt <= 3'd0;
      end else if (dv_fall && (line_cnt != 3'd4)) begin
        line_cnt <= line_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    row_in[0] = row0_i;
    row_in[1] = row1_i;
    row_in[2] = row2_i;
    row_in[3] = row3_i;
    row_in[4] = row4_i;
    for (int k = 0; k < 5; k++) begin
      row_mask[k] = (3'(k) > line_cnt) ? '0 : row_in[k];
    end
  end

  // Window clears whenever dv_i is low, which provides left-edge zero padding.
  always_ff @(posedge clk) begin
    if (rst || !dv_i) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          win[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < 5; r++) begin
        win[r][0] <= row_mask[r];
        for (int c = 1; c < 5; c++) begin
          win[r][c] <= win[r][c-1];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 25; i++) begin
      pix_ext[i]  = PW'({1'b0, win[i/5][i%5]});
      coef_ext[i] = PW'($signed(coeff_sh[i*COEFW +: COEFW]));
      prod_c[i]   = pix_ext[i] * coef_ext[i];
    end
  end

  always_comb begin
    for (int r = 0; r < 5; r++) begin
      row_sum_c[r] = '0;
      for (int c = 0; c < 5; c++) begin
        row_sum_c[r] = row_sum_c[r] + SW'(prod[5*r+c]);
      end
    end
    total_c = '0;
    for (int r = 0; r < 5; r++) begin
      total_c = total_c + row_sum[r];
    end
  end

  // The shift amount travels with the data so each pixel is normalised by its own kernel's shift.
  always_comb begin
    shifted = total >>> shift_s4;
    if (shifted[SW-1]) begin
      pix_c = '0;
    end else if (|shifted[SW-2:COLORDEPTH]) begin
      pix_c = '1;
    end else begin
      pix_c = shifted[COLORDEPTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 25; i++) begin
        prod[i] <= '0;
      end
      for (int r = 0; r < 5; r++) begin
        row_sum[r] <= '0;
      end
      total    <= '0;
      shift_s2 <= 4'd0;
      shift_s3 <= 4'd0;
      shift_s4 <= 4'd0;
      data_o   <= '0;
      dv_d     <= 5'd0;
      hs_d     <= 5'd0;
      vs_d     <= 5'd0;
    end else begin
      for (int i = 0; i < 25; i++) begin
        prod[i] <= prod_c[i];
      end
      for (int r = 0; r < 5; r++) begin
        row_sum[r] <= row_sum_c[r];
      end
      total    <= total_c;
      shift_s2 <= shift_sh;
      shift_s3 <= shift_s2;
      shift_s4 <= shift_s3;
      data_o   <= pix_c;
      dv_d     <= {dv_d[3:0], dv_i};
      hs_d     <= {hs_d[3:0], hs_i};
      vs_d     <= {vs_d[3:0], vs_i};
    end
  end

  assign dv_o = dv_d[4];
  assign hs_o = hs_d[4];
  assign vs_o = vs_d[4];

endmodule

// File: tb/tb_conv5x5_filter.sv
// tb_conv5x5_filter: randomized stimulus with a direct-formula convolution model feeding
// an expected-value queue; a negedge monitor pops and compares every valid output.
module tb_conv5x5_filter;

  logic        clock = 1'b0;
  logic        reset;
  logic        dv_i;
  logic        hs_i;
  logic        vs_i;
  logic [7:0]  row0_i;
  logic [7:0]  row1_i;
  logic [7:0]  row2_i;
  logic [7:0]  row3_i;
  logic [7:0]  row4_i;
  logic [199:0] coeff_i;
  logic [3:0]  shift_i;
  logic        dv_o;
  logic        hs_o;
  logic        vs_o;
  logic [7:0]  data_o;

  typedef struct {
    int data;
    int hs;
    int vs;
    int cyc;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   cycleNo    = 0;

  int   kCoef[25];
  int   kShift;
  int   modelLines;
  int   xPos;
  int   lineBuf[5][64];
  bit   prevDv;
  bit   prevVs;
  int   rowVal[5];
  int   kernBuf[25];

  conv5x5_filter #(.COLORDEPTH(8), .COEFW(8)) dut (
    .clk     (clock),
    .rst     (reset),
    .dv_i    (dv_i),
    .hs_i    (hs_i),
    .vs_i    (vs_i),
    .row0_i  (row0_i),
    .row1_i  (row1_i),
    .row2_i  (row2_i),
    .row3_i  (row3_i),
    .row4_i  (row4_i),
    .coeff_i (coeff_i),
    .shift_i (shift_i),
    .dv_o    (dv_o),
    .hs_o    (hs_o),
    .vs_o    (vs_o),
    .data_o  (data_o)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleNo++;

  // Single comparison point: bumps the counters and reports any difference.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycleNo);
    end
  endtask

  // Output = sum over the kernel of coefficient times the masked pixel c positions back in
  // the current line (zero before the line start), arithmetically shifted then clamped.
  function automatic int modelPixel();
    int sum;
    int s;
    sum = 0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (xPos - c >= 0) sum += kCoef[5*r+c] * lineBuf[r][xPos-c];
      end
    end
    s = sum >>> kShift;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  // Drives one clock cycle of inputs and advances the frame-level model alongside.
  task automatic applyStimulus(input bit dv, input bit hs, input bit vs);
    exp_t e;
    dv_i   = dv;
    hs_i   = hs;
    vs_i   = vs;
    row0_i = 8'(rowVal[0]);
    row1_i = 8'(rowVal[1]);
    row2_i = 8'(rowVal[2]);
    row3_i = 8'(rowVal[3]);
    row4_i = 8'(rowVal[4]);
    if (vs && !prevVs) begin
      for (int k = 0; k < 25; k++) kCoef[k] = int'($signed(coeff_i[k*8 +: 8]));
      kShift = int'(shift_i);
    end
    if (dv) begin
      for (int r = 0; r < 5; r++) lineBuf[r][xPos] = (r > modelLines) ? 0 : rowVal[r];
      e.data = modelPixel();
      e.hs   = int'(hs);
      e.vs   = int'(vs);
      e.cyc  = cycleNo;
      expQ.push_back(e);
      if (xPos < 63) xPos++;
    end else begin
      xPos = 0;
    end
    if (vs && !prevVs) modelLines = 0;
    else if (prevDv && !dv && modelLines < 4) modelLines++;
    prevDv = dv;
    prevVs = vs;
    @(posedge clock);
    #1;
  endtask

  // One-cycle synchronous reset; the model returns to the identity kernel and line 0.
  task automatic applyReset(input bit dvDuring);
    reset = 1'b1;
    dv_i  = dvDuring;
    hs_i  = 1'b0;
    vs_i  = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    expQ.delete();
    for (int k = 0; k < 25; k++) kCoef[k] = (k == 12) ? 1 : 0;
    kShift     = 0;
    modelLines = 0;
    xPos       = 0;
    prevDv     = 1'b0;
    prevVs     = 1'b0;
    checkOutput("reset_dv_o", int'(dv_o), 0);
    checkOutput("reset_hs_o", int'(hs_o), 0);
    checkOutput("reset_vs_o", int'(vs_o), 0);
    checkOutput("reset_data_o", int'(data_o), 0);
  endtask

  // Puts kernBuf on coeff_i and loads it with a vsync pulse during blanking.
  task automatic setKernel(input int sh, input bit pulseVs);
    for (int k = 0; k < 25; k++) coeff_i[k*8 +: 8] = 8'(kernBuf[k]);
    shift_i = 4'(sh);
    if (pulseVs) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
  endtask

  // mode 0: all rows = val; mode 1: random rows; mode 2: random rows with row2 = 10*(x+1).
  // vsAt >= 0 raises vs_i for two pixels starting there.
  task automatic sendLine(input int n, input int mode, input int val, input int vsAt);
    for (int x = 0; x < n; x++) begin
      for (int r = 0; r < 5; r++) begin
        rowVal[r] = (mode == 0) ? val : int'($urandom_range(0, 255));
      end
      if (mode == 2) rowVal[2] = 10 * (x + 1);
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), (vsAt >= 0 && x >= vsAt && x < vsAt + 2));
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic fillKernel(input int v);
    for (int k = 0; k < 25; k++) kernBuf[k] = v;
  endtask

  // Monitor: every valid output must match the oldest outstanding expectation, exactly
  // five cycles after its pixel was presented.
  always @(negedge clock) begin
    if (dv_o === 1'b1) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_dv_o: got data %0d, expected no output", data_o);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("data_o", int'(data_o), e.data);
        checkOutput("hs_o", int'(hs_o), e.hs);
        checkOutput("vs_o", int'(vs_o), e.vs);
        checkOutput("latency", cycleNo - e.cyc, 5);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    coeff_i = '0;
    shift_i = 4'd0;
    row0_i  = 8'd0;
    row1_i  = 8'd0;
    row2_i  = 8'd0;
    row3_i  = 8'd0;
    row4_i  = 8'd0;
    for (int r = 0; r < 5; r++) rowVal[r] = 0;
    applyReset(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] identity kernel after reset, no vsync");
    sendLine(6, 1, 0, -1);
    sendLine(6, 1, 0, -1);
    sendLine(5, 2, 0, -1);

    $display("[TB] box kernel, shift 5, all rows 255");
    fillKernel(1);
    setKernel(5, 1'b1);
    for (int l = 0; l < 5; l++) sendLine(8, 0, 255, -1);

    $display("[TB] clamp low and high");
    fillKernel(0);
    kernBuf[0] = -1;
    setKernel(0, 1'b1);
    for (int l = 0; l < 2; l++) sendLine(6, 0, 50, -1);
    fillKernel(1);
    setKernel(0, 1'b1);
    for (int l = 0; l < 5; l++) sendLine(6, 0, 255, -1);

    $display("[TB] row mask over lines 0..5");
    fillKernel(0);
    for (int r = 0; r < 5; r++) kernBuf[5*r] = 1;
    setKernel(0, 1'b1);
    for (int l = 0; l < 6; l++) sendLine(4, 0, 10, -1);

    $display("[TB] random kernels and pixels");
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 25; k++) kernBuf[k] = int'($urandom_range(0, 255));
      setKernel(int'($urandom_range(0, 15)), 1'b1);
      for (int l = 0; l < 6; l++) sendLine(12, 1, 0, -1);
    end

    $display("[TB] mid-frame coefficient change, then vsync during active pixels");
    for (int k = 0; k < 25; k++) kernBuf[k] = int'($urandom_range(0, 255));
    setKernel(int'($urandom_range(0, 15)), 1'b0);
    sendLine(10, 1, 0, -1);
    sendLine(10, 1, 0, -1);
    sendLine(12, 1, 0, 6);
    for (int l = 0; l < 4; l++) sendLine(10, 1, 0, -1);

    $display("[TB] reset during an active line");
    sendLine(10, 1, 0, -1);
    for (int x = 0; x < 4; x++) begin
      for (int r = 0; r < 5; r++) rowVal[r] = int'($urandom_range(0, 255));
      applyStimulus(1'b1, 1'b0, 1'b0);
    end
    applyReset(1'b1);
    sendLine(6, 1, 0, -1);
    sendLine(6, 1, 0, -1);
    sendLine(8, 2, 0, -1);

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clock);
    #1;
    checkOutput("drain_outstanding", expQ.size(), 0);
    repeat (3) @(posedge clock);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
